// File: rtl/bus_restoring_divider.sv
// -----------------------------------------------------------------------------
// bus_restoring_divider
//
// Unsigned restoring divider with a valid/ready byte-bus front end and back end.
// Operands arrive as BUS_W-bit beats (dividend MS beat first, then divisor MS
// beat first). The quotient and remainder are computed one bit per clock. They
// leave as BUS_W-bit beats: quotient MS->LS, then remainder MS->LS.
//
// Parameters
//   DATA_W : operand / quotient / remainder width (multiple of BUS_W, >= 2*BUS_W)
//   BUS_W  : bus beat width
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  block accepts operand beats (LOAD state)
//   in_data    in   operand beat [BUS_W]
//   out_valid  out  result beat valid (SEND state)
//   out_ready  in   consumer accepts result beat
//   out_data   out  result beat [BUS_W]
//   busy       out  high while dividing or sending
//   div_err    out  divide-by-zero flag (only driven with BUSDIV_DIVZERO_EN)
//
// Build option
//   BUSDIV_DIVZERO_EN : when defined, a zero divisor skips iteration and
//                       reports div_err during SEND. When undefined, a zero
//                       divisor iterates normally and div_err is tied low.
//                       The quotient and remainder are the same in both builds.
// -----------------------------------------------------------------------------
module bus_restoring_divider #(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             busy,
    output logic             div_err
);

    localparam int BEATS  = DATA_W / BUS_W;
    localparam int NBEATS = 2 * BEATS;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int STEP_W = $clog2(DATA_W);
    // The final operand beat is taken straight from in_data, so the load
    // register only has to hold the earlier beats.
    localparam int LOAD_W = 2 * DATA_W - BUS_W;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DIV,
        ST_SEND
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_beat_cnt;   // shared by input and output beat counting
    logic [LOAD_W-1:0]   r_load;
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   r_d;
    // The partial remainder is only ever written with a non-negative value
    // smaller than 2^DATA_W, so its top bit is always zero and is not stored.
    logic [DATA_W-1:0]   r_p;
    logic [STEP_W-1:0]   r_step;
    logic [2*DATA_W-1:0] r_out_sr;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
`ifdef BUSDIV_DIVZERO_EN
    logic                r_div_err;
`endif

    logic                w_in_fire;
    logic                w_out_fire;
    logic [2*DATA_W-1:0] w_load_next;
    logic [DATA_W:0]     w_shifted;
    logic [DATA_W:0]     w_trial;
    logic                w_neg;
    logic [DATA_W-1:0]   w_p_next;
    logic [DATA_W-1:0]   w_q_next;

    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = out_ready & r_out_valid;
    assign w_load_next = {r_load, in_data};

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor. A set MSB means the trial
    // went negative, so the shifted value is kept and the quotient bit is 0.
    assign w_shifted = {r_p, r_q[DATA_W-1]};
    assign w_trial   = w_shifted - {1'b0, r_d};
    assign w_neg     = w_trial[DATA_W];
    assign w_p_next  = w_neg ? w_shifted[DATA_W-1:0] : w_trial[DATA_W-1:0];
    assign w_q_next  = {r_q[DATA_W-2:0], ~w_neg};

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the order
    // of the statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset as well as the control
            // registers, so an aborted operation leaves no operand or result
            // behind.
            r_state     <= ST_LOAD;
            r_beat_cnt  <= '0;
            r_load      <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_p         <= '0;
            r_step      <= '0;
            r_out_sr    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef BUSDIV_DIVZERO_EN
            r_div_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_load <= w_load_next[LOAD_W-1:0];
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_beat_cnt <= '0;
                            r_q        <= w_load_next[2*DATA_W-1:DATA_W];
                            r_d        <= w_load_next[DATA_W-1:0];
                            r_p        <= '0;
                            r_step     <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_DIV;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end

                ST_DIV: begin
`ifdef BUSDIV_DIVZERO_EN
                    // A zero divisor is known on the first DIV cycle; the
                    // iterated answer would be {all ones, dividend}, so
                    // produce it directly.
                    if (r_d == '0) begin
                        r_out_sr    <= {{DATA_W{1'b1}}, r_q};
                        r_out_valid <= 1'b1;
                        r_div_err   <= 1'b1;
                        r_state     <= ST_SEND;
                    end else begin
`else
                    begin
`endif
                        r_q    <= w_q_next;
                        r_p    <= w_p_next;
                        r_step <= r_step + 1'b1;
                        if (r_step == LAST_STEP) begin
                            r_out_sr    <= {w_q_next, w_p_next};
                            r_out_valid <= 1'b1;
                            r_state     <= ST_SEND;
                        end
                    end
                end

                ST_SEND: begin
                    if (w_out_fire) begin
                        // Zeros shift in, so out_data is zero again once
                        // every beat has been sent.
                        r_out_sr <= {r_out_sr[2*DATA_W-BUS_W-1:0], {BUS_W{1'b0}}};
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_beat_cnt  <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
`ifdef BUSDIV_DIVZERO_EN
                            r_div_err   <= 1'b0;
`endif
                            r_state     <= ST_LOAD;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_sr[2*DATA_W-1 -: BUS_W];
    assign busy      = r_busy;
`ifdef BUSDIV_DIVZERO_EN
    assign div_err   = r_div_err;
`else
    assign div_err   = 1'b0;
`endif

endmodule

// File: doc/bus_restoring_divider.md
# bus_restoring_divider

Parametrised bus-interfaced restoring divider with integrated datapath. It collects an unsigned dividend and divisor as BUS_W-bit beats over a valid/ready input port and computes quotient and remainder one bit per cycle. It returns the quotient, then the remainder, as BUS_W-bit beats over a valid/ready output port. It is the single-block successor to the fixed 16-bit/8-bit in-wrapper, divider and out-wrapper trio, and sits directly on the accelerator's byte bus.

## Interface
- DATA_W, 16: operand, quotient and remainder width. Must be a multiple of BUS_W and at least 2·BUS_W.
- BUS_W, 8: bus beat width. BEATS = DATA_W/BUS_W.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data holds a valid operand beat.
- in_ready  out  1  block accepts a beat. Transfer occurs when in_valid & in_ready are high at a rising edge.
- in_data  in  BUS_W  operand beat.
- out_valid  out  1  out_data holds a valid result beat.
- out_ready  in  1  consumer accepts a beat. Transfer occurs when out_valid & out_ready are high at a rising edge.
- out_data  out  BUS_W  result beat.
- busy  out  1  high in DIV and SEND.
- div_err  out  1  divide-by-zero flag; see Configuration.

## Operation
- States: LOAD, DIV, SEND.
  - Reset enters LOAD. Beat counter is cleared and all datapath registers are cleared.
- LOAD:
  - in_ready=1.
  - Each accepted beat shifts into a 2·DATA_W load register, MS beat first: BEATS dividend beats, then BEATS divisor beats.
  - The beat that completes the count (beat 2·BEATS) moves the block to DIV. It loads Q←dividend, D←divisor, the (DATA_W+1)-bit partial remainder P←0, and the step counter←0.
- DIV:
  - in_ready=0, out_valid=0.
  - Each cycle performs one step:
    - trial = {P[DATA_W-1:0], Q[DATA_W-1]} − {0, D}
    - If trial[DATA_W]=1 (negative): P←{P[DATA_W-1:0], Q[DATA_W-1]} and Q←{Q[DATA_W-2:0], 0}.
    - Otherwise: P←trial and Q←{Q[DATA_W-2:0], 1}.
  - After DATA_W steps, the block loads the output shift register with {Q, P[DATA_W-1:0]} and moves to SEND.
- SEND:
  - out_valid=1.
  - out_data = MS BUS_W of the output shift register.
  - Order is quotient MS→LS, then remainder MS→LS, for 2·BEATS beats.
  - Each accepted beat shifts left by BUS_W.
  - The last accepted beat returns the block to LOAD, with out_valid low in the next cycle.
- Arithmetic is unsigned. Without the macro, a divisor of 0 iterates normally and yields Q=all ones and R=dividend.
- in_valid outside LOAD is ignored; there is no buffering. out_ready outside SEND is ignored.

## Timing
- Reset values:
  - in_ready=1 (LOAD)
  - out_valid=0
  - out_data=0
  - busy=0
  - div_err=0
- Reset asserted mid-DIV or mid-SEND aborts the operation immediately. Partial operands and results are discarded and no beat is emitted.
- Latency: if the last input beat is accepted at edge k, out_valid is high from the cycle following edge k+DATA_W.
- Minimum operation is 2·BEATS + DATA_W + 2·BEATS cycles with no stalls.
- The input side tolerates gaps: the beat counter holds while in_valid=0.
- The output side tolerates backpressure: out_data and out_valid stay stable while out_ready=0.
- in_ready returns to 1 in the cycle after the final output handshake. A new operand beat can be accepted at the next edge.

## Configuration
- BUSDIV_DIVZERO_EN defined:
  - On entry to DIV with D=0, the block skips iteration. At the next edge it loads {all ones, dividend} and enters SEND, so latency is 1 cycle.
  - div_err is registered high on entry to SEND and held until the final output handshake; it clears on return to LOAD.
- BUSDIV_DIVZERO_EN undefined: division by zero takes DATA_W cycles and div_err is tied 0.
- In both modes Q and R values are identical.

## Test plan
- DATA_W=16, BUS_W=8: in 0x03,0xE8,0x00,0x07 (1000/7) -> out 0x00,0x8E,0x00,0x06, with out_valid first high 16 cycles after the last input edge.
- Dividend smaller than divisor: 0x0005/0x0009 -> out 0x00,0x00,0x00,0x05. 0xFFFF/0x0001 -> out 0xFF,0xFF,0x00,0x00.
- Divide by zero 0x1234/0x0000 -> out 0xFF,0xFF,0x12,0x34 in both builds.
  - With macro: div_err=1 during SEND, latency 1.
  - Without macro: div_err=0, latency 16.
- Random in_valid gaps and out_ready low for 1–5 cycles:
  - Results are unchanged.
  - out_data is stable while stalled.
  - No beat is duplicated or dropped.
  - in_ready=0 throughout DIV and SEND.
- Assert rst 5 cycles into DIV, then release and send 0x00,0x64,0x00,0x0A -> out 0x00,0x0A,0x00,0x00. No stale beats appear.
- DATA_W=32, BUS_W=8, back-to-back operations 0xDEADBEEF/0x00010000 then 100/3 -> Q=0x0000DEAD, R=0x0000BEEF, then Q=33, R=1.
